// File: rtl/plus_rr_sched.sv
// Round-robin scheduler sharing one W-bit `plus` datapath among N_REQ requesters.
// Each service drives pu_a for SETTLE cycles, then captures pu_y into the requester's slot.
module plus_rr_sched #(
  parameter int N_REQ  = 4,
  parameter int W      = 4,
  parameter int SETTLE = 2
) (
  input  logic               CLOCK_50,
  input  logic               KEY0,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*W-1:0] operand,
  output logic [N_REQ-1:0]   gnt,
  output logic [W-1:0]       pu_a,
  input  logic [W-1:0]       pu_y,
  output logic [N_REQ*W-1:0] res,
  output logic [N_REQ-1:0]   res_valid,
  output logic               busy
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int CW = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_CAPTURE
  } state_t;

  state_t          state, state_nx;
  logic [CW-1:0]   cnt;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   sel;
  logic [PW-1:0]   pick;
  logic [PW-1:0]   idx_p;
  int unsigned     idx_u;
  logic            found;

  // Scan ptr+1, ptr+2, ... so the requester served last has lowest priority.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx_u = 0;
    idx_p = '0;
    for (int unsigned i = 1; i <= N_REQ; i++) begin
      idx_u = (32'(ptr) + i) % N_REQ;
      idx_p = PW'(idx_u);
      if (!found && req[idx_p]) begin
        found = 1'b1;
        pick  = idx_p;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:    if (found) state_nx = S_WAIT;
      S_WAIT:    if (cnt == CW'(1)) state_nx = S_CAPTURE;
      S_CAPTURE: state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge KEY0) begin
    if (!KEY0) begin
      cnt       <= '0;
      pu_a      <= '0;
      sel       <= '0;
      ptr       <= PW'(N_REQ - 1);
      res       <= '0;
      res_valid <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            pu_a <= operand[32'(pick)*W +: W];
            sel  <= pick;
            cnt  <= CW'(SETTLE);
          end
        end
        S_WAIT: cnt <= cnt - CW'(1);
        S_CAPTURE: begin
          res[32'(sel)*W +: W] <= pu_y;
          res_valid[sel]       <= 1'b1;
          ptr                  <= sel;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gnt  = '0;
    busy = (state != S_IDLE);
    if (state == S_CAPTURE) gnt[sel] = 1'b1;
  end

endmodule

// File: tb/tb_plus_rr_sched.sv
// Scoreboard bench for plus_rr_sched with a `plus` model of pu_y = pu_a + 1 (mod 16).
module tb_plus_rr_sched;

  localparam int N = 4;
  localparam int W = 4;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N*W-1:0] operand = '0;
  logic [N-1:0]   gnt;
  logic [W-1:0]   pu_a;
  logic [W-1:0]   pu_y;
  logic [N*W-1:0] res;
  logic [N-1:0]   res_valid;
  logic           busy;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int       idx;
    logic [3:0] a;
    logic [3:0] y;
  } exp_t;
  exp_t sb[$];

  plus_rr_sched #(.N_REQ(N), .W(W), .SETTLE(2)) dut (
    .CLOCK_50 (clk),
    .KEY0     (rst_n),
    .req      (req),
    .operand  (operand),
    .gnt      (gnt),
    .pu_a     (pu_a),
    .pu_y     (pu_y),
    .res      (res),
    .res_valid(res_valid),
    .busy     (busy)
  );

  assign pu_y = pu_a + 4'd1;

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int idx, input logic [3:0] a, input logic [3:0] y);
    exp_t e;
    e.idx = idx; e.a = a; e.y = y;
    sb.push_back(e);
  endtask

  // Monitor: every grant pulse pops one expectation; result checked after the capture edge.
  initial begin
    exp_t e;
    logic [N-1:0] oh;
    forever begin
      @(negedge clk);
      if (rst_n && gnt != '0) begin
        if (sb.size() == 0) begin
          chk("unexpected_gnt", 32'(gnt), 32'h0);
        end else begin
          e = sb.pop_front();
          oh = '0;
          oh[e.idx] = 1'b1;
          chk("gnt_onehot", 32'(gnt), 32'(oh));
          chk("pu_a_at_gnt", 32'(pu_a), 32'(e.a));
          @(posedge clk); #1;
          chk("res_slot", 32'(res[e.idx*W +: W]), 32'(e.y));
          chk("res_valid_bit", 32'(res_valid[e.idx]), 32'h1);
        end
      end
    end
  end

  // Counts n grant pulses (optionally checking a 4-cycle period), then drops req.
  task automatic wait_grants(input int n, input bit chk_period, input string name);
    int seen = 0;
    int cyc = 0;
    int last = -1;
    while (seen < n && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (gnt != '0) begin
        if (chk_period && last >= 0) chk({name, "_period"}, 32'(cyc - last), 32'd4);
        last = cyc;
        seen++;
        if (seen == n) req = '0;
      end
    end
    if (seen < n) chk({name, "_timeout"}, 32'(seen), 32'(n));
  endtask

  task automatic wait_busy(input string name);
    int cyc = 0;
    while (!busy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_busy"}, 32'(busy), 32'h1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_pu_a", 32'(pu_a), 32'h0);
    chk("rst_res", res, 32'h0);
    chk("rst_res_valid", 32'(res_valid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;

    // Single request
    @(negedge clk);
    operand = 16'h0005;
    req = 4'b0001;
    push(0, 4'h5, 4'h6);
    wait_busy("t1");
    chk("t1_pu_a", 32'(pu_a), 32'h5);
    wait_grants(1, 1'b0, "t1");
    @(negedge clk);
    chk("t1_res_valid", 32'(res_valid), 32'h1);

    // All requesting: order 0,1,2,3,0 from a fresh pointer
    do_reset();
    operand = 16'h4321;
    req = 4'b1111;
    push(0, 4'h1, 4'h2);
    push(1, 4'h2, 4'h3);
    push(2, 4'h3, 4'h4);
    push(3, 4'h4, 4'h5);
    push(0, 4'h1, 4'h2);
    wait_grants(5, 1'b1, "t2");
    @(negedge clk);
    chk("t2_res", res, 32'h5432);
    chk("t2_res_valid", 32'(res_valid), 32'hF);

    // Wrap: F+1 -> 0, other slots untouched
    operand = 16'h432F;
    req = 4'b0001;
    push(0, 4'hF, 4'h0);
    wait_grants(1, 1'b0, "t3");
    @(negedge clk);
    chk("t3_res", res, 32'h5430);

    // req1 dropped during WAIT still completes
    operand = 16'h437F;
    req = 4'b0010;
    push(1, 4'h7, 4'h8);
    wait_busy("t4");
    @(negedge clk);
    req = '0;
    wait_grants(1, 1'b0, "t4");
    repeat (2) @(negedge clk);
    chk("t4_idle", 32'(busy), 32'h0);
    chk("t4_res", res, 32'h5480);

    // Reset during WAIT aborts, then req2 is serviced afresh
    operand = 16'h0A00;
    req = 4'b0100;
    wait_busy("t5");
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("t5_gnt", 32'(gnt), 32'h0);
    chk("t5_res", res, 32'h0);
    chk("t5_res_valid", 32'(res_valid), 32'h0);
    chk("t5_pu_a", 32'(pu_a), 32'h0);
    repeat (3) @(negedge clk);
    push(2, 4'hA, 4'hB);
    rst_n = 1'b1;
    wait_grants(1, 1'b0, "t5");
    @(negedge clk);
    chk("t5_res_after", res, 32'h0B00);

    // Operand changed after acceptance has no effect
    operand = 16'h0003;
    req = 4'b0001;
    push(0, 4'h3, 4'h4);
    wait_busy("t6");
    operand = 16'h0009;
    @(negedge clk);
    chk("t6_pu_a_hold", 32'(pu_a), 32'h3);
    wait_grants(1, 1'b0, "t6");
    repeat (3) @(negedge clk);
    chk("t6_res", res, 32'h0B04);
    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/plus_rr_sched.md
Name: plus_rr_sched

Overview:
- Round-robin scheduler that time-multiplexes one shared 4-bit `plus` datapath unit among N_REQ requesters.
- Each requester presents an operand and a request. The scheduler drives the single `plus` input bus, waits a fixed settle time, then captures the `plus` output into a per-requester result register.
- Sits between switch/key front-end logic and the `hex_7seg` display path on the DE2 board top.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- W, 4, operand/result width in bits, matching the `plus` datapath.
- SETTLE, 2, cycles the operand is held on the `plus` inputs before capture (>=1).

Ports:
- CLOCK_50  in  1  system clock (50 MHz), all state rising-edge.
- KEY0  in  1  reset, asynchronous, active-low (pushbutton); asserts immediately, releases synchronously to CLOCK_50 at the board level.
- req  in  N_REQ  per-requester request level.
- operand  in  N_REQ*W  operands; slot i = operand[i*W +: W].
- gnt  out  N_REQ  one-hot completion pulse, one cycle, for the requester just served.
- pu_a  out  W  registered operand driven to the shared `plus` inputs.
- pu_y  in  W  result returned from `plus` (combinational).
- res  out  N_REQ*W  per-requester result registers; slot i = res[i*W +: W].
- res_valid  out  N_REQ  slot i holds a result captured since reset.
- busy  out  1  high in WAIT and CAPTURE.

Behaviour:
- Reset (KEY0=0, asynchronous) clears everything:
  - gnt=0, pu_a=0, res=0, res_valid=0, busy=0, state=IDLE, settle counter=0.
  - RR pointer=N_REQ-1, so requester 0 has highest priority first.
- FSM states: IDLE, WAIT, CAPTURE.
- IDLE:
  - If any req is high at the edge, select the first set req scanning ptr+1, ptr+2, ... mod N_REQ.
  - On that edge: latch operand[sel] into pu_a, store sel, load counter=SETTLE, go to WAIT.
  - If no req, stay in IDLE; pu_a holds its last value.
- WAIT: counter decrements each edge; the edge on which it reaches 0 moves the FSM to CAPTURE.
- CAPTURE (one cycle):
  - gnt[sel]=1.
  - On the exiting edge: res[sel] <= pu_y, res_valid[sel] <= 1, ptr <= sel, go to IDLE.
- Latency: acceptance at edge 0 -> gnt high during the cycle after edge SETTLE -> res updated at edge SETTLE+1.
- Back-to-back service period is SETTLE+2 cycles; IDLE always lasts at least one cycle.
- pu_a is stable from the accept edge through the capture edge and does not change in WAIT or CAPTURE.
- operand[sel] changing after acceptance has no effect on the current service.
- Requester protocol: hold req high until gnt pulses.
  - req dropped mid-service: the service still completes, res is written and gnt still pulses.
  - req high in the cycle after gnt: treated as a new request.
- Fairness: a requester just served has lowest priority next, so with all req high the grant order is 0,1,2,3,0,... Starvation-free; worst-case wait is N_REQ*(SETTLE+2) cycles.
- req arriving during WAIT/CAPTURE is ignored until IDLE; no queueing beyond the level itself.
- res_valid bits are sticky until reset; re-service overwrites res[sel] and leaves res_valid set.
- Reset mid-operation aborts the service: no gnt, no res write.
- Width rule: pu_y is captured verbatim (W bits); no carry or overflow is retained.

Test Plan:
Bench `plus` model: pu_y = (pu_a+1) mod 16. SETTLE=2, N_REQ=4, W=4.
- Reset, then req=0001, operand0=4'h5 -> pu_a=5 from edge 0; gnt=0001 in cycle 3; res0=6 and res_valid=0001 after edge 3.
- req=1111, operands 1,2,3,4 held -> grants 0,1,2,3,0 every 4 cycles; res={5,4,3,2} (slot3..0).
- operand0=4'hF -> res0=0 (wrap), no other slot changes.
- req1 high then dropped during WAIT -> gnt=0010 still pulses; res1 written; IDLE afterward.
- KEY0 low during WAIT for req2 -> gnt never pulses; res2=0, res_valid=0, pu_a=0; after release, req2 still high is serviced afresh.
- Operand changed during WAIT (3->9) -> pu_a stays 3; result=4.
